seg_pipe_adder: RTL and testbench
=================================

Name: seg_pipe_adder

Overview:
- Parametrised successor to the team's single-cycle 4-bit full adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in, splitting the carry chain into SEG-bit segments, one segment per register stage, to meet timing at wide WIDTH.
- Sits between upstream datapath producers and downstream consumers using a valid/ready handshake.
- Throughput is one operation per cycle, with full backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, segment width in bits, i.e. carry-chain length per stage; 1 <= SEG <= WIDTH.
- STAGES, WIDTH/SEG, derived (localparam), number of pipeline stages and the latency in cycles.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: add, 1: subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out (add) or borrow-out (sub).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset: this block has one clock `clk` and a synchronous active-low reset `rst_n`. While rst_n=0 at a rising edge, clear every stage valid bit. Outputs after reset: out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 follows from out_valid=0.
- Reset mid-operation: all in-flight beats are discarded, with no partial outputs.
- Arithmetic, add (sub=0): {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1).
- Arithmetic, sub (sub=1): sum = a - b - c_in (mod 2^WIDTH), implemented as a + ~b + ~c_in. c_out = 1 iff a < b + c_in unsigned (borrow), i.e. the inverted internal carry.
- ovf: 1 iff the operands fed to the MSB adder (a and b-or-~b) share a sign and sum's sign differs.
- Segmentation: stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and of the effective B using the carry registered from stage k-1.
  - Stage 0 uses the effective carry-in.
  - Upper operand bits travel in skew registers.
  - Lower result bits travel in de-skew registers, so that the full sum leaves the final stage aligned.
  - The sub flag travels with its beat.
- Latency: a beat accepted at edge N appears on out_valid/sum at edge N+STAGES when no stall occurs.
- Handshake:
  - Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Advance enable en = in_ready; every stage register loads only when en=1.
  - en=0: all stages hold. sum/c_out/ovf are stable while out_valid=1 and out_ready=0.
  - Bubbles: when en=1 and in_valid=0, a valid=0 bubble enters stage 0. Data registers may load don't-care, but outputs present no new valid.
- Simultaneous events: out_ready=1 with out_valid=1 and in_valid=1 completes one output and one input in the same cycle, so throughput is 1/cycle.
- Boundary: SEG=WIDTH gives STAGES=1, a single registered full adder with latency 1.
- Wrap-around: wrap at 2^WIDTH, with carry reported on c_out.

Decomposition:
- Package seg_adder_pkg:
  - Default WIDTH/SEG constants.
  - A function computing STAGES with an elaboration check (WIDTH % SEG == 0).
  - A typedef for the per-beat control bundle {valid, sub}.
- Sub-module seg_add_stage (SEG-bit adder slice with carry-in/carry-out): purely combinational. The top instantiates it STAGES times in a generate loop and owns all registers.

Test Plan:
- WIDTH=32, SEG=8, add a=0xFFFF_FFFF, b=0x0000_0001, c_in=0 -> after 4 cycles sum=0x0000_0000, c_out=1, ovf=0. This checks carry ripple across all 4 stages.
- Sub a=5, b=7, c_in=0 -> sum=0xFFFF_FFFE, c_out=1 (borrow), ovf=0. Sub a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, c_out=0, ovf=1.
- Back-to-back 100 random beats with out_ready=1 -> one result per cycle, in order, each matching the reference model. out_valid first rises exactly 4 cycles after the first accept.
- Backpressure: hold out_ready=0 for 6 cycles with a full pipeline -> in_ready=0, outputs are stable, and no beat is lost or duplicated. On release the results drain in order.
- Assert rst_n=0 for one edge with 3 beats in flight -> next cycle out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1. No stale result ever appears.
- Parameter sweep SEG=32 and SEG=1 (WIDTH=32) -> latency 1 and 32 respectively, with arithmetic identical to the reference model.

Source files
------------

// File: rtl/seg_adder_pkg.sv
// Shared defaults, stage-count helper and per-beat control bundle for the
// segmented pipelined adder.
package seg_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;

  typedef struct packed {
    logic valid;
    logic sub;
  } beat_ctrl_t;

  // Yields 0 for an illegal split so the instantiating module's check trips.
  function automatic int unsigned calc_stages(int unsigned width, int unsigned seg);
    if (seg == 0 || seg > width || (width % seg) != 0) return 0;
    return width / seg;
  endfunction

endpackage

// File: rtl/seg_add_stage.sv
// One SEG-bit slice of the carry chain; purely combinational, registered by
// the enclosing pipeline.
module seg_add_stage #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};

endmodule

// File: rtl/seg_pipe_adder.sv
// Add/subtract with the carry chain split into SEG-bit segments, one segment
// per register stage, behind a valid/ready handshake with full backpressure.
module seg_pipe_adder
  import seg_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG);
  localparam int unsigned SKEW   = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES == 0) begin : g_param_check
    $error("seg_pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

  beat_ctrl_t ctrl_q  [STAGES];
  beat_ctrl_t ctrl_in [STAGES];
  logic [WIDTH-1:0] a_q    [SKEW];
  logic [WIDTH-1:0] b_q    [SKEW];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] res_in [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic             cy_q   [STAGES];
  logic [STAGES-1:0][SEG-1:0] seg_a, seg_b, seg_sum;
  logic [STAGES-1:0]          seg_ci, seg_co;
  logic en, ovf_d, ovf_q;

  assign out_valid = ctrl_q[STAGES-1].valid;
  assign in_ready  = !out_valid || out_ready;
  assign en        = in_ready;

  // Subtraction is a + ~b + ~c_in; B is inverted once at entry and the
  // inverted operand rides the skew registers.
  always_comb begin
    ctrl_in[0] = '{valid: in_valid, sub: sub};
    a_in[0]    = a;
    b_in[0]    = sub ? ~b : b;
    res_in[0]  = '0;
    seg_ci[0]  = c_in ^ sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      ctrl_in[k] = ctrl_q[k-1];
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      res_in[k]  = res_q[k-1];
      seg_ci[k]  = cy_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_a[k] = a_in[k][k*SEG +: SEG];
      seg_b[k] = b_in[k][k*SEG +: SEG];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    seg_add_stage #(.SEG(SEG)) u_add (
      .a     (seg_a[k]),
      .b     (seg_b[k]),
      .c_in  (seg_ci[k]),
      .sum   (seg_sum[k]),
      .c_out (seg_co[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_d[k] = res_in[k];
      res_d[k][k*SEG +: SEG] = seg_sum[k];
    end
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
            (res_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        res_q[k]  <= '0;
        cy_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= ctrl_in[k];
        res_q[k]  <= res_d[k];
        cy_q[k]   <= seg_co[k];
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign sum   = res_q[STAGES-1];
  assign c_out = cy_q[STAGES-1] ^ ctrl_q[STAGES-1].sub;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Randomised bench for seg_pipe_adder at SEG=8, 32 and 1 (WIDTH=32), all three
// driven in lockstep and scored against an arithmetic reference.
module tb_seg_pipe_adder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{32 / 8, 32 / 32, 32 / 1};

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, c_in, sub;
  logic [31:0] a, b;
  logic [NI-1:0] ir, ov, co, of;
  logic [31:0] sm [NI];

  always #5 clk = ~clk;

  seg_pipe_adder #(.WIDTH(32), .SEG(8)) u_seg8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .c_out(co[0]), .ovf(of[0]));

  seg_pipe_adder #(.WIDTH(32), .SEG(32)) u_seg32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .c_out(co[1]), .ovf(of[1]));

  seg_pipe_adder #(.WIDTH(32), .SEG(1)) u_seg1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm[2]), .c_out(co[2]), .ovf(of[2]));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  bit          stall_free = 1'b1;

  logic [33:0] exp_val [NI][256];
  int          exp_acc [NI][256];
  int unsigned wr [NI];
  int unsigned rd [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [33:0] ref_model(logic [31:0] x, logic [31:0] y, logic ci, logic sb);
    longint ux, uy, sx, sy, ur, sr, cl;
    logic [31:0] s;
    logic c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cl = longint'(ci);
    if (!sb) begin
      ur = ux + uy + cl;
      sr = sx + sy + cl;
      c  = (ur > 64'sd4294967295);
    end else begin
      ur = ux - uy - cl;
      sr = sx - sy - cl;
      c  = (ux < uy + cl);
    end
    s = ur[31:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, c, s};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at the falling edge, then score the handshakes that the
  // next rising edge will perform.
  task automatic cycle(input logic rst, input logic v, input logic rdy,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
    int unsigned idx;
    logic [33:0] e;
    @(negedge clk);
    rst_n = rst; in_valid = v; out_ready = rdy;
    a = av; b = bv; c_in = ci; sub = sb;
    #1;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NI; i++) rd[i] = wr[i];
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (rd[i] != wr[i]) begin
        idx = rd[i] % 256;
        e = exp_val[i][idx];
        if (stall_free)
          check($sformatf("valid_timing[%0d]", i), 32'(ov[i]),
                32'(exp_acc[i][idx] + LAT[i] <= cyc));
        if (ov[i]) begin
          check($sformatf("sum[%0d]", i), sm[i], e[31:0]);
          check($sformatf("c_out[%0d]", i), 32'(co[i]), 32'(e[32]));
          check($sformatf("ovf[%0d]", i), 32'(of[i]), 32'(e[33]));
          if (rdy) rd[i]++;
        end
      end else begin
        check($sformatf("idle_valid[%0d]", i), 32'(ov[i]), 32'd0);
      end
      if (v && ir[i]) begin
        idx = wr[i] % 256;
        exp_val[i][idx] = ref_model(av, bv, ci, sb);
        exp_acc[i][idx] = cyc;
        wr[i]++;
      end
    end
  endtask

  task automatic rand_cycle(input logic v, input logic rdy);
    cycle(1'b1, v, rdy, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    for (int n = 0; n < 45; n++) rand_cycle(1'b0, 1'b1);
    for (int i = 0; i < NI; i++)
      check($sformatf("drained[%0d]", i), wr[i] - rd[i], 32'd0);
    stall_free = 1'b1;
  endtask

  task automatic reset_and_check(input logic v);
    cycle(1'b0, v, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst_sum[%0d]", i), sm[i], 32'd0);
      check($sformatf("rst_c_out[%0d]", i), 32'(co[i]), 32'd0);
      check($sformatf("rst_ovf[%0d]", i), 32'(of[i]), 32'd0);
      check($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    for (int i = 0; i < NI; i++) begin wr[i] = 0; rd[i] = 0; end

    cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    reset_and_check(1'b0);

    // Directed corner beats, back to back.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drain();

    for (int n = 0; n < 100; n++) rand_cycle(1'b1, 1'b1);
    drain();

    // Fill every pipeline, then stall the output for 6 cycles.
    for (int n = 0; n < 40; n++) rand_cycle(1'b1, 1'b1);
    stall_free = 1'b0;
    for (int n = 0; n < 6; n++) begin
      rand_cycle(1'b1, 1'b0);
      for (int i = 0; i < NI; i++)
        check($sformatf("stall_in_ready[%0d]", i), 32'(ir[i]), 32'd0);
    end
    drain();

    stall_free = 1'b0;
    for (int n = 0; n < 300; n++)
      rand_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    drain();

    // Three beats in flight, then a one-edge reset discards them.
    for (int n = 0; n < 3; n++) rand_cycle(1'b1, 1'b1);
    reset_and_check(1'b1);
    for (int n = 0; n < 40; n++) rand_cycle(1'b0, 1'b1);

    for (int n = 0; n < 20; n++) rand_cycle(1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
